// File: rtl/hazard_sequencer.sv
// Hazard detection and pipeline hold/flush control for the 5-stage MIPS core.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module hazard_sequencer #(
  parameter int unsigned MULDIV_LAT = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_hilo_rd,
  input  logic        id_muldiv,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        ex_muldiv_start,
  input  logic        imem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        muldiv_busy,
  output logic [31:0] stall_count
);

  localparam int unsigned CNT_W = $clog2(MULDIV_LAT + 1);
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;

  // Busy tracker: a start loads LAT-1 remaining cycles, a start while busy restarts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= StIdle;
      cnt    <= '0;
      busy_r <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (ex_muldiv_start) begin
            state  <= StBusy;
            cnt    <= CntLoad;
            busy_r <= 1'b1;
          end
        end
        StBusy: begin
          if (ex_muldiv_start) begin
            cnt <= CntLoad;
          end else if (cnt == CntOne) begin
            state  <= StIdle;
            cnt    <= '0;
            busy_r <= 1'b0;
          end else begin
            cnt <= cnt - CntOne;
          end
        end
        default: begin
          state  <= StIdle;
          cnt    <= '0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign muldiv_busy = busy_r;

  logic hz_lu;
  logic hz_md;
  logic hz_im;

  // A load targeting $zero never produces a value, so it cannot create a dependency.
  assign hz_lu = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign hz_md = busy_r && (id_hilo_rd || id_muldiv);
  assign hz_im = !imem_ready;

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!reset_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // Redirect wins over every stall: both younger instructions are squashed.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hz_lu || hz_md) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (hz_im) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= '0;
    end else if (!pc_en && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_count = stall_cnt_r;
`else
  assign stall_count = 32'h0;
`endif

`ifndef SYNTHESIS
  a_flush_implies_en: assert property (@(posedge clock) disable iff (!reset_n)
    ifid_flush |-> ifid_en);
  a_busy_has_count: assert property (@(posedge clock) disable iff (!reset_n)
    muldiv_busy |-> (cnt != '0));
  a_idle_not_busy: assert property (@(posedge clock) disable iff (!reset_n)
    (state == StIdle) |-> !muldiv_busy);
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: vector table, multi-cycle sequences,
// scoreboard queue of expected outputs checked on the falling edge.
module tb_hazard_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_hilo_rd, id_muldiv, ex_mem_read;
  logic        ex_branch_taken, ex_muldiv_start, imem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, muldiv_busy;
  logic [31:0] stall_count;

  always #5 clock = ~clock;

  hazard_sequencer #(.MULDIV_LAT(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_hilo_rd      (id_hilo_rd),
    .id_muldiv       (id_muldiv),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_muldiv_start (ex_muldiv_start),
    .imem_ready      (imem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .muldiv_busy     (muldiv_busy),
    .stall_count     (stall_count)
  );

  // exp = {pc_en, ifid_en, ifid_flush, idex_flush, muldiv_busy}
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       hilo_rd;
    logic       muldiv;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic       branch;
    logic       start;
    logic       ready;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t        exp_q[$];
  vec_t        table_v[12];
  int          checks   = 0;
  int          failures = 0;
  int unsigned sc_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                              input logic hilo_rd, input logic muldiv, input logic mem_read,
                              input logic [4:0] xrt, input logic branch, input logic start,
                              input logic ready, input logic [4:0] exp, input string name);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.hilo_rd = hilo_rd; v.muldiv = muldiv;
    v.mem_read = mem_read; v.ex_rt = xrt; v.branch = branch; v.start = start;
    v.ready = ready; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_hilo_rd = 1'b0; id_muldiv = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0;
    imem_ready = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    @(posedge clock);
    #1;
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_hilo_rd = v.hilo_rd;
    id_muldiv = v.muldiv; ex_mem_read = v.mem_read; ex_rt = v.ex_rt;
    ex_branch_taken = v.branch; ex_muldiv_start = v.start; imem_ready = v.ready;
    exp_q.push_back(v);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out"}, {27'b0, pc_en, ifid_en, ifid_flush, idex_flush, muldiv_busy},
        {27'b0, 5'b00110});
    chk({tag, "_stall_count"}, stall_count, 32'h0);
  endtask

  // Scoreboard: each driven cycle is compared mid-cycle, then the stall model advances.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      vec_t        v;
      logic [31:0] sc_exp;
      v = exp_q.pop_front();
`ifdef HAZARD_PERF_EN
      sc_exp = sc_model;
`else
      sc_exp = 32'h0;
`endif
      chk({v.name, "_out"}, {27'b0, pc_en, ifid_en, ifid_flush, idex_flush, muldiv_busy},
          {27'b0, v.exp});
      chk({v.name, "_stall_count"}, stall_count, sc_exp);
      if (!v.exp[4]) sc_model++;
    end
  end

  initial begin
    //                 rs     rt    urt hl md mr ex_rt  br st rdy  exp
    table_v[0]  = mk(5'd3,  5'd4,  0, 0, 0, 0, 5'd0,  0, 0, 1, 5'b11000, "tbl_none");
    table_v[1]  = mk(5'd8,  5'd1,  0, 0, 0, 1, 5'd8,  0, 0, 1, 5'b00010, "tbl_lu_rs");
    table_v[2]  = mk(5'd0,  5'd0,  1, 0, 0, 1, 5'd0,  0, 0, 1, 5'b11000, "tbl_zero");
    table_v[3]  = mk(5'd2,  5'd9,  0, 0, 0, 1, 5'd9,  0, 0, 1, 5'b11000, "tbl_rt_unused");
    table_v[4]  = mk(5'd2,  5'd9,  1, 0, 0, 1, 5'd9,  0, 0, 1, 5'b00010, "tbl_lu_rt");
    table_v[5]  = mk(5'd6,  5'd5,  0, 0, 0, 1, 5'd5,  0, 0, 1, 5'b11000, "tbl_no_match");
    table_v[6]  = mk(5'd1,  5'd2,  0, 0, 0, 0, 5'd0,  0, 0, 0, 5'b01100, "tbl_imiss");
    table_v[7]  = mk(5'd8,  5'd2,  0, 0, 0, 1, 5'd8,  0, 0, 0, 5'b00010, "tbl_lu_over_im");
    table_v[8]  = mk(5'd8,  5'd2,  0, 0, 0, 1, 5'd8,  1, 0, 1, 5'b11110, "tbl_br_over_lu");
    table_v[9]  = mk(5'd1,  5'd2,  0, 0, 0, 0, 5'd0,  1, 0, 0, 5'b11110, "tbl_br_over_im");
    table_v[10] = mk(5'd1,  5'd2,  0, 1, 1, 0, 5'd0,  0, 0, 1, 5'b11000, "tbl_md_idle");
    table_v[11] = mk(5'd7,  5'd7,  1, 0, 0, 0, 5'd7,  0, 0, 1, 5'b11000, "tbl_no_load");

    set_idle();
    reset_n = 1'b0;
    #3;
    chk_reset_outputs("por");
    #9;
    reset_n = 1'b1;

    foreach (table_v[i]) apply(table_v[i]);

    // Mult/div with mflo waiting in ID: three busy stall cycles, then release.
    apply(mk(5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 1, 1, 5'b11000, "md_start"));
    for (int i = 0; i < 3; i++)
      apply(mk(5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0, 1, 5'b00011, $sformatf("md_stall%0d", i)));
    apply(mk(5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0, 1, 5'b11000, "md_release"));

    // Restart while busy extends occupancy by a full period.
    apply(mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 5'b11000, "rs_start"));
    apply(mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 5'b11001, "rs_restart"));
    for (int i = 0; i < 3; i++)
      apply(mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b11001, $sformatf("rs_busy%0d", i)));
    apply(mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b11000, "rs_done"));

    // Branch overrides an md stall; the stall resumes afterwards.
    apply(mk(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 1, 1, 5'b11000, "bm_start"));
    apply(mk(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 1, 0, 1, 5'b11111, "bm_branch"));
    apply(mk(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 1, 5'b00011, "bm_stall0"));
    apply(mk(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 1, 5'b00011, "bm_stall1"));
    apply(mk(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 1, 5'b11000, "bm_release"));

    // Reset in the middle of a busy period abandons the operation.
    apply(mk(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 5'b11000, "rb_start"));
    apply(mk(5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0, 1, 5'b00011, "rb_busy"));
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    set_idle();
    #1;
    chk_reset_outputs("rb_async");
    sc_model = 0;
    @(posedge clock);
    #2;
    chk_reset_outputs("rb_held");
    reset_n = 1'b1;
    apply(mk(5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0, 1, 5'b11000, "rb_abandoned"));

    // Fetch miss for three cycles.
    for (int i = 0; i < 3; i++)
      apply(mk(5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 0, 5'b01100, $sformatf("im_miss%0d", i)));
    apply(mk(5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b11000, "im_resume"));
    @(negedge clock);
    #1;
`ifdef HAZARD_PERF_EN
    chk("im_stall_total", stall_count, 32'd3);
`else
    chk("im_stall_total", stall_count, 32'd0);
`endif

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
